// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready bus between the memory stage and the data memory.
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: EX/MEM and MEM/WB registers, data-memory handshake,
// load alignment, store strobes and forwarding/hazard outputs.
module mem_wb_stage (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_result,
    input  logic [31:0]           ex_store_data,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_reg_we,
    input  logic                  ex_mem_rr,
    input  logic                  ex_mem_we,
    input  logic [2:0]            ex_funct3,
    output logic                  stall,
    mem_wb_stage_if.master        dmem,
    output logic [31:0]           previous,
    output logic [4:0]            prev_rd,
    output logic                  prev_reg_we,
    output logic                  prev_mem_rr,
    output logic [31:0]           writeback,
    output logic [4:0]            wb_rd,
    output logic                  wb_reg_we,
    output logic                  wb_mem_rr,
    output logic                  misaligned
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;

    logic        m_valid;
    logic [31:0] m_result;
    logic [31:0] m_store_data;
    logic [4:0]  m_rd;
    logic        m_reg_we;
    logic        m_mem_rr;
    logic        m_mem_we;
    logic [2:0]  m_funct3;

    logic        w_valid;
    logic [31:0] w_data;
    logic [4:0]  w_rd;
    logic        w_reg_we;
    logic        w_mem_rr;
    logic        w_mis;

    logic        in_access;
    logic        m_mis;
    logic        ex_access;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] store_wdata;
    logic [3:0]  store_strb;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

    assign in_access = (state == ACCESS);
    assign stall     = in_access & ~dmem.dmem_ready;
    assign m_mis     = m_valid & (m_mem_rr | m_mem_we) & is_misaligned(m_funct3, m_result[1:0]);
    assign ex_access = ex_valid & (ex_mem_rr | ex_mem_we) & ~is_misaligned(ex_funct3, ex_result[1:0]);

    assign dmem.dmem_req   = in_access;
    assign dmem.dmem_we    = in_access & m_mem_we;
    assign dmem.dmem_addr  = {m_result[31:2], 2'b00};
    assign dmem.dmem_wdata = store_wdata;
    assign dmem.dmem_wstrb = (in_access & m_mem_we) ? store_strb : 4'b0000;

    always_comb begin
        store_wdata = m_store_data;
        store_strb  = 4'b1111;
        case (m_funct3[1:0])
            2'b00: begin
                store_wdata = {4{m_store_data[7:0]}};
                store_strb  = 4'b0001 << m_result[1:0];
            end
            2'b01: begin
                store_wdata = {2{m_store_data[15:0]}};
                store_strb  = m_result[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = 8'(dmem.dmem_rdata >> {m_result[1:0], 3'b000});
        ld_half   = m_result[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        load_data = dmem.dmem_rdata;
        case (m_funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: ;
        endcase
    end

    // M only advances when not stalled; W takes a bubble on every stalled edge
    // so the held instruction is written exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            m_valid      <= 1'b0;
            m_result     <= '0;
            m_store_data <= '0;
            m_rd         <= '0;
            m_reg_we     <= 1'b0;
            m_mem_rr     <= 1'b0;
            m_mem_we     <= 1'b0;
            m_funct3     <= '0;
            w_valid      <= 1'b0;
            w_data       <= '0;
            w_rd         <= '0;
            w_reg_we     <= 1'b0;
            w_mem_rr     <= 1'b0;
            w_mis        <= 1'b0;
        end else if (stall) begin
            w_valid  <= 1'b0;
            w_reg_we <= 1'b0;
            w_mem_rr <= 1'b0;
            w_mis    <= 1'b0;
        end else begin
            state        <= ex_access ? ACCESS : IDLE;
            m_valid      <= ex_valid;
            m_result     <= ex_result;
            m_store_data <= ex_store_data;
            m_rd         <= ex_rd;
            m_reg_we     <= ex_valid & ex_reg_we;
            m_mem_rr     <= ex_valid & ex_mem_rr;
            m_mem_we     <= ex_valid & ex_mem_we;
            m_funct3     <= ex_funct3;
            w_valid      <= m_valid;
            w_data       <= (m_mem_rr & ~m_mis) ? load_data : m_result;
            w_rd         <= m_rd;
            w_reg_we     <= m_reg_we & ~m_mem_we & ~m_mis;
            w_mem_rr     <= m_mem_rr;
            w_mis        <= m_mis;
        end
    end

    assign previous    = m_result;
    assign prev_rd     = m_rd;
    assign prev_reg_we = m_valid & m_reg_we & ~m_mem_we;
    assign prev_mem_rr = m_valid & m_mem_rr;

    assign writeback   = w_data;
    assign wb_rd       = w_rd;
    assign wb_reg_we   = w_valid & w_reg_we;
    assign wb_mem_rr   = w_valid & w_mem_rr;
    assign misaligned  = w_mis;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory and writeback pipeline stage that sits directly downstream of the execute stage. Holds the EX/MEM and MEM/WB pipeline registers and runs the data-memory request/ready handshake. Aligns load data, builds store byte strobes, and stalls upstream while an access is outstanding. Drives the `previous`/`prev_*` and `writeback`/`wb_*` forwarding and hazard signals that the execute stage consumes.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: execute output is a real instruction; 0 means a bubble.
- `ex_result` in 32: ALU result, which is the memory address for loads and stores.
- `ex_store_data` in 32: forwarded rs2 value.
- `ex_rd` in 5, `ex_reg_we` in 1, `ex_mem_rr` in 1 (load), `ex_mem_we` in 1 (store), `ex_funct3` in 3.
- `stall` out 1: upstream must hold its state; this block ignores `ex_*` while high.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (word-aligned, bits [1:0] = 0), `dmem_wdata` out 32, `dmem_wstrb` out 4.
- `dmem_ready` in 1, `dmem_rdata` in 32: word read data, valid when ready.
- `previous` out 32, `prev_rd` out 5, `prev_reg_we` out 1, `prev_mem_rr` out 1: M-register contents.
- `writeback` out 32, `wb_rd` out 5, `wb_reg_we` out 1, `wb_mem_rr` out 1: W-register contents, wired to the regfile write port.
- `misaligned` out 1: one-cycle pulse while a misaligned access occupies W.

## Operation
- M register: captures `ex_*` each edge when `stall`=0. A bubble (`ex_valid`=0) clears the M valid bit, `reg_we`, `mem_rr` and `mem_we`.
- `prev_reg_we` = M.valid & M.reg_we, and is forced to 0 for stores. `prev_mem_rr` = M.valid & M.mem_rr. `previous` = M.result.
- Misalignment check on the M address:
  - halfword (funct3[1:0]=01) with addr[0]=1 is misaligned;
  - word (funct3[1:0]=10 or 11) with addr[1:0]≠0 is misaligned.
- A misaligned access issues no request. It moves to W with `reg_we`=0 and `misaligned`=1.
- FSM states:
  - IDLE: M holds no pending aligned memory operation.
  - ACCESS: M holds an aligned load or store and the memory has not yet acknowledged it.
  - The state is entered on the edge that latches such an operation into M.
- In ACCESS: `dmem_req`=1, with `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wstrb` derived from M.
  - If `dmem_ready`=0, then `stall`=1.
  - If `dmem_ready`=1, the access completes this cycle: M moves to W and M loads the next `ex_*`. The next state is ACCESS if the new M content is an aligned memory op, otherwise IDLE.
- `stall` = (state==ACCESS) & ~`dmem_ready`. This is a combinational path from `dmem_ready`.
- While `stall`=1, W captures a bubble each edge, so no instruction is duplicated.
- Store strobes and write data:
  - SB: strobe 0001<<addr[1:0], write data is the low byte replicated ×4.
  - SH: strobe 0011<<(2·addr[1]), write data is the low half replicated ×2.
  - SW and funct3 11: strobe 1111.
- Load extraction from `dmem_rdata`, using the byte/half selected by addr[1:0]:
  - LB and LH are sign-extended; LBU and LHU are zero-extended.
  - LW, and the reserved codes 011, 110 and 111, return the full word.
- W data is the extracted load data for loads, otherwise M.result.
- `wb_reg_we` = W.valid & W.reg_we. `wb_mem_rr` = W.valid & W.mem_rr.
- Writes to x0 pass through unchanged. The regfile and the execute stage's rd≠0 checks discard them.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - state is IDLE;
  - all valid, we, rr, req and `misaligned` outputs are 0;
  - all data, address, strobe and rd outputs are 0.
- Reset asserted during ACCESS drops `dmem_req` immediately and abandons the transaction. The memory must tolerate this.
- The first edge after `rst_n` rises may latch `ex_*`.
- Non-memory instruction: latched into M at edge N, reaches W at edge N+1, and is written to the regfile on edge N+2.
- Load or store with a 0-wait memory (`dmem_ready`=1 in the first ACCESS cycle): no stall, same latency as a non-memory instruction.
- Each wait cycle adds exactly one stall cycle and one W bubble.
- `dmem_ready` is sampled only while `dmem_req`=1. Ready outside ACCESS is ignored.
- Back-to-back memory ops: the next op enters M on the completion edge and requests in the very next cycle, with no idle gap.

## Test plan
- Back-to-back ALU ops: rd=5 with result 0x1234, then rd=6 with result 0x5678, ready tied 1.
  - `prev_rd`/`previous` = 5/0x1234 after edge 1, then `wb_rd`/`writeback` = 5/0x1234 after edge 2; no stall.
- LB from addr 0x103 with rdata 0x80FF_0000 → `writeback`=0xFFFF_FF80. LBU from the same address → 0x0000_0080. LHU from 0x102 with the same rdata → 0x0000_80FF.
- SH of 0xABCD_1234 to 0x206 → `dmem_addr`=0x204, `dmem_wstrb`=1100, `dmem_wdata`=0x1234_1234, `dmem_we`=1, `wb_reg_we`=0.
- LW with ready held low for 3 cycles:
  - `stall`=1 for exactly 3 cycles and W shows 3 bubbles (`wb_reg_we`=0);
  - on the ready cycle `stall`=0 and the next edge writes rdata to W.
- LW to 0x101 → no `dmem_req`; the following cycle has `misaligned`=1 for one cycle and `wb_reg_we`=0.
- Assert `rst_n`=0 mid-ACCESS → `dmem_req`, `stall` and all we outputs drop to 0 without waiting for `clk`; a later load after release completes normally.
